// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector family.
package seq_det_pkg;

  localparam logic [31:0] DEFAULT_PATTERN = 32'b101;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // fill counts 0..pat_w, so it needs pat_w+1 distinct codes
  function automatic int fill_w(input int pat_w);
    return clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Bit-stream, pattern-load and status bundle for seq_detect_param.
interface seq_detect_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  localparam int FILL_W = fill_w(PAT_W);

  logic              input_bit;
  logic              in_valid;
  logic [PAT_W-1:0]  pat_in;
  logic              pat_load;
  logic              cnt_clr;
  logic              output_bit;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  match_count;

  modport master (
    output input_bit, in_valid, pat_in, pat_load, cnt_clr,
    input  output_bit, fill, match_count
  );

  modport slave (
    input  input_bit, in_valid, pat_in, pat_load, cnt_clr,
    output output_bit, fill, match_count
  );
endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector; match state is implied by fill
// (0 = empty, <PAT_W = filling, PAT_W = armed).
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN[PAT_W-1:0],
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_detect_param_if.slave  bus
);
  localparam int                FILL_W   = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_q, out_d;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              match;

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bus.input_bit};
    fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    pat_d      = pat_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    out_d      = out_q;
    match      = 1'b0;
    // A load discards the bit presented in the same cycle
    if (bus.pat_load) begin
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
      out_d  = 1'b0;
    end else if (bus.in_valid) begin
      match = (hist_shift == pat_q) && (fill_inc == FILL_MAX);
      out_d = match;
      if (match && OVERLAP == 0) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
    end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match),
    .clr   (bus.cnt_clr),
    .cnt   (bus.match_count)
  );

  assign bus.output_bit = out_q;
  assign bus.fill       = fill_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed checks of seq_detect_param in three configurations sharing one stimulus.
module tb_seq_detect_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ib = 1'b0, iv = 1'b0, pl = 1'b0, cc = 1'b0;
  logic [2:0] pi = 3'b000;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_W(3), .CNT_W(8)) if0 ();
  seq_detect_param_if #(.PAT_W(3), .CNT_W(8)) if1 ();
  seq_detect_param_if #(.PAT_W(3), .CNT_W(2)) if2 ();

  assign if0.input_bit = ib; assign if0.in_valid = iv; assign if0.pat_in = pi;
  assign if0.pat_load = pl;  assign if0.cnt_clr = cc;
  assign if1.input_bit = ib; assign if1.in_valid = iv; assign if1.pat_in = pi;
  assign if1.pat_load = pl;  assign if1.cnt_clr = cc;
  assign if2.input_bit = ib; assign if2.in_valid = iv; assign if2.pat_in = pi;
  assign if2.pat_load = pl;  assign if2.cnt_clr = cc;

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(8))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(2))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one bit for one clock; sample 1 time unit after the edge
  task automatic send(input logic b, input logic v);
    ib = b; iv = v;
    @(posedge clk); #1;
    ib = 1'b0; iv = 1'b0; pl = 1'b0; cc = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0);
  endtask

  // Asynchronous pulse placed between clock edges
  task automatic pulse_rst();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(if0.output_bit), 0);
    chk("arst_fill", 32'(if0.fill), 0);
    chk("arst_cnt", 32'(if0.match_count), 0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #3;
    chk("rst_out", 32'(if0.output_bit), 0);
    chk("rst_fill", 32'(if0.fill), 0);
    chk("rst_cnt", 32'(if0.match_count), 0);
    #4 rst_n = 1'b1;

    // Stream 1,0,1,0,1: overlap on u0/u2, non-overlap on u1
    send(1, 1); chk("s1_fill", 32'(if0.fill), 1);
    send(0, 1); chk("s2_fill", 32'(if0.fill), 2); chk("s2_out", 32'(if0.output_bit), 0);
    send(1, 1); chk("s3_out", 32'(if0.output_bit), 1); chk("s3_fill", 32'(if0.fill), 3);
                chk("s3_out_nov", 32'(if1.output_bit), 1); chk("s3_fill_nov", 32'(if1.fill), 0);
    send(0, 1); chk("s4_out", 32'(if0.output_bit), 0); chk("s4_out_nov", 32'(if1.output_bit), 0);
                chk("s4_fill_nov", 32'(if1.fill), 1);
    send(1, 1); chk("s5_out", 32'(if0.output_bit), 1); chk("s5_cnt", 32'(if0.match_count), 2);
                chk("s5_out_nov", 32'(if1.output_bit), 0); chk("s5_fill_nov", 32'(if1.fill), 2);
                chk("s5_cnt_nov", 32'(if1.match_count), 1);

    // Gaps of 4 idle cycles between bits
    pulse_rst();
    send(1, 1); idle(4); chk("gap1_fill", 32'(if0.fill), 1);
    send(0, 1); idle(4); chk("gap2_fill", 32'(if0.fill), 2); chk("gap2_out", 32'(if0.output_bit), 0);
    send(1, 1); chk("gap3_out", 32'(if0.output_bit), 1);
    idle(4);    chk("gap_hold_out", 32'(if0.output_bit), 1); chk("gap_hold_fill", 32'(if0.fill), 3);
                chk("gap_cnt", 32'(if0.match_count), 1);

    // Runtime load with a valid bit in the same cycle
    pulse_rst();
    pl = 1'b1; pi = 3'b110; send(1, 1);
    chk("load_fill", 32'(if0.fill), 0); chk("load_out", 32'(if0.output_bit), 0);
    send(1, 1); send(1, 1); chk("ld2_out", 32'(if0.output_bit), 0);
    send(0, 1); chk("ld3_out", 32'(if0.output_bit), 1); chk("ld3_cnt", 32'(if0.match_count), 1);
    pl = 1'b1; pi = 3'b011; send(0, 0);
    chk("reload_cnt", 32'(if0.match_count), 1); chk("reload_out", 32'(if0.output_bit), 0);

    // Saturation on the 2-bit counter, then clear on a matching edge
    pulse_rst();
    send(1, 1); send(0, 1);
    send(1, 1); chk("sat_c1", 32'(if2.match_count), 1);
    send(0, 1); send(1, 1); chk("sat_c2", 32'(if2.match_count), 2);
    send(0, 1); send(1, 1); chk("sat_c3", 32'(if2.match_count), 3);
    send(0, 1); send(1, 1); chk("sat_c4", 32'(if2.match_count), 3);
    send(0, 1); send(1, 1); chk("sat_c5", 32'(if2.match_count), 3);
    send(0, 1); cc = 1'b1; send(1, 1);
    chk("clr_cnt", 32'(if2.match_count), 0); chk("clr_out", 32'(if2.output_bit), 1);

    // Mid-pattern reset, then loaded pattern lost on reset
    pulse_rst();
    send(1, 1); send(0, 1); chk("mid_fill", 32'(if0.fill), 2);
    pulse_rst();
    pl = 1'b1; pi = 3'b011; send(0, 0);
    pulse_rst();
    send(1, 1); send(0, 1); send(1, 1);
    chk("revert_out", 32'(if0.output_bit), 1); chk("revert_cnt", 32'(if0.match_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised, runtime-programmable serial pattern detector; successor to the fixed three-bit Moore detectors in the FPGA lab set.
- Accepts one qualified bit per cycle and compares the last PAT_W accepted bits against a loadable pattern.
- Flags each match with a registered Moore output, supports overlapping or non-overlapping detection, and keeps a saturating match count.
- Sits between a bit-serial source (switch debouncer, UART RX bit stream) and display/LED logic.

Parameters:
- PAT_W, 3, pattern length in bits; legal range 2..32.
- PATTERN, 3'b101, reset-time pattern; MSB is the first bit of the sequence in time.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match.
- CNT_W, 8, width of match counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- input_bit  in  1  serial data bit.
- in_valid  in  1  input_bit is consumed only when 1.
- pat_in  in  PAT_W  new pattern value.
- pat_load  in  1  load pat_in into the pattern register.
- cnt_clr  in  1  synchronous clear of match_count.
- output_bit  out  1  Moore match flag.
- fill  out  clog2(PAT_W+1)  number of valid history bits, saturating at PAT_W.
- match_count  out  CNT_W  saturating number of matches.

Behaviour:
- Reset (rst_n low, async): pattern register = PATTERN, history = 0, fill = 0, output_bit = 0, match_count = 0.
- Accepted bit: history shifts left and input_bit enters at the LSB; fill increments up to PAT_W.
- Match condition, evaluated on an accepted bit using the next-history value:
  - next_history == pattern, and
  - next fill == PAT_W.
- output_bit is registered (Moore):
  - Set on the clock edge that accepts the completing bit, so it is visible 1 cycle after the bit is presented.
  - Recomputed on every accepted bit.
  - Holds its value while in_valid = 0.
- Overlap behaviour on a match:
  - OVERLAP = 1: history and fill are kept, so the suffix of the match can start the next one.
  - OVERLAP = 0: fill is forced to 0 and history to 0 on the match edge; output_bit is still set to 1.
- match_count increments by 1 per match and saturates at all ones (no wrap).
- pat_load = 1 has highest priority among synchronous events:
  - pattern register <= pat_in; history, fill and output_bit are cleared.
  - input_bit in that cycle is discarded, even with in_valid = 1.
  - match_count is unaffected.
- cnt_clr = 1: match_count <= 0. If a match occurs in the same cycle, clear wins and the result is 0; output_bit still behaves normally.
- pat_load and cnt_clr in the same cycle: both take effect.
- Reset asserted mid-sequence: all state returns to reset values immediately; a pattern loaded at runtime is lost and PATTERN is restored.
- No combinational path from any input to any output.
- The state machine is implicit in the fill count: EMPTY (fill = 0) → FILLING (0 < fill < PAT_W) → ARMED (fill = PAT_W).
  - ARMED → EMPTY only on a match with OVERLAP = 0, on pat_load, or on reset.

Decomposition:
- Package seq_det_pkg holds:
  - clog2 constant function
  - default pattern constant
  - fill-width helper
- One sub-module: sat_counter (CNT_W, increment/clear inputs, clear priority), reusable by other lab blocks.
- History/fill/match logic stays in the top module.

Test Plan:
- Defaults (PAT_W = 3, 101, OVERLAP = 1); stream 1,0,1,0,1 with in_valid held high → output_bit = 1 in the cycles after the 3rd and 5th bits, 0 after the 4th; match_count = 2.
- OVERLAP = 0, same stream 1,0,1,0,1 → output_bit = 1 only after the 3rd bit; fill = 0 after it, fill = 2 after the 5th; match_count = 1.
- Stream 1,0,1 with in_valid = 0 for 4 cycles inserted between bits → single match; output_bit stays 1 while idle after the match; fill does not advance during the gaps.
- pat_load with pat_in = 3'b110 together with in_valid = 1 and bit 1 → that bit is ignored and fill = 0; then bits 1,1,0 → match, match_count increments.
- CNT_W = 2: drive 5 overlapping matches → count reads 1, 2, 3, 3, 3; cnt_clr on the same cycle as the 6th match → count = 0 and output_bit = 1.
- rst_n pulsed low asynchronously after 1,0 (mid-pattern) and after a runtime pattern load → all outputs 0 with no clock edge; pattern reverts to 101; the next stream 1,0,1 matches.
